axi_fifo_dly: RTL

- Parametrised successor to the team's 80-entry delay-skew AXI-Stream FIFO: single-clock FIFO whose write address can be re-targeted at run time by a signed delay, inserting or removing samples in the stream (channelizer phase/alignment trim).
- Adds generic data/address/delay widths, TLAST carriage, an occupancy count, a programmable almost-full flag, and a registered delay path that needs no external adder.
- Sits between the polyphase filter output and the FFT input in the M/2 channelizer.

---
 rtl/axi_fifo_dly_pkg.sv | 23 ++
 rtl/axi_fifo_dly_if.sv | 12 +
 rtl/axi_fifo_dly_ostage.sv | 49 ++++
 rtl/axi_fifo_dly.sv | 99 +++++++++
 4 files changed

// File: rtl/axi_fifo_dly_pkg.sv
// Shared types and helpers for the delay-skew AXI-Stream FIFO and its output stage.
package axi_fifo_dly_pkg;

  // Output stage-pair fill state: bit 1 = d1 (output) valid, bit 0 = d0 (skid) valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_D0    = 2'b01,
    OCC_D1    = 2'b10,
    OCC_FULL  = 2'b11
  } occ_t;

  // One extra bit over the address so full and empty are distinguishable on wrap.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [31:0] sext_delay(input logic [31:0] value, input int unsigned width);
    logic [31:0] sign_bit;
    sign_bit = 32'd1 << (width - 1);
    return (value ^ sign_bit) - sign_bit;
  endfunction

endpackage

// File: rtl/axi_fifo_dly_if.sv
// AXI-Stream beat bundle (valid/ready/data/last) with master and slave views.
interface axi_fifo_dly_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, tdata, tlast, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axi_fifo_dly_ostage.sv
// Two-deep output register/skid pair that pops a source when it has room and
// presents d1 downstream; data and valid hold while the consumer stalls.
module axi_fifo_dly_ostage
  import axi_fifo_dly_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             src_pop,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data,
  input  logic             dst_ready
);

  occ_t             occ, occ_nxt;
  logic             d1_load;
  logic [WIDTH-1:0] d0, d1;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    src_pop = 1'b0;
    d1_load = 1'b0;
    occ_nxt = occ;
    src_pop = src_valid && ((occ != OCC_FULL) || dst_ready);
    d1_load = occ[0] && (!occ[1] || dst_ready);
    occ_nxt = occ_t'({d1_load || (occ[1] && !dst_ready),
                      src_pop || (occ[0] && !d1_load)});
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      occ <= OCC_EMPTY;
      d0  <= '0;
      d1  <= '0;
    end else begin
      occ <= occ_nxt;
      if (src_pop) d0 <= src_data;
      if (d1_load) d1 <= d0;
    end
  end

  assign dst_valid = occ[1];
  assign dst_data  = d1;

endmodule

// File: rtl/axi_fifo_dly.sv
// Single-clock AXI-Stream FIFO whose write address can be re-targeted by a signed delay.
// Build with AXI_FIFO_DLY_DELAY_EN defined to enable delay re-targeting; otherwise a plain FIFO.
module axi_fifo_dly
  import axi_fifo_dly_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DELAY_WIDTH = 9,
  parameter int AF_THRESH   = (2 ** ADDR_WIDTH) - 4
) (
  input  logic                   clk,
  input  logic                   sync_reset,
  axi_fifo_dly_if.slave          s_axis,
  input  logic [DELAY_WIDTH-1:0] delay,
  axi_fifo_dly_if.master         m_axis,
  output logic [ADDR_WIDTH:0]    occupancy,
  output logic                   almost_full
);

  localparam int PTR_W  = ptr_width(ADDR_WIDTH);
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int WORD_W = DATA_WIDTH + 1;

  logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};
  logic [WORD_W-1:0] rd_word, out_word;
  logic [PTR_W-1:0]  wr_ptr, wr_addr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_nxt, rd_ptr_nxt;
  logic              full, empty, wr_en, rd_en;

  // Full compares against the (possibly skewed) write address, empty against the beat count.
  assign full  = (wr_addr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_addr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign wr_en = s_axis.tvalid && !full;
  assign s_axis.tready = !full;

  assign wr_ptr_nxt = wr_en ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign rd_ptr_nxt = rd_en ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign occupancy  = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      almost_full <= (wr_ptr_nxt - rd_ptr_nxt) >= PTR_W'(AF_THRESH);
    end
  end

`ifdef AXI_FIFO_DLY_DELAY_EN
  logic [DELAY_WIDTH-1:0] dly_reg;

  // A new delay is applied only on an accepted beat; it takes effect from the following beat.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wr_addr <= '0;
      dly_reg <= '0;
    end else if (wr_en) begin
      if (delay != dly_reg) begin
        wr_addr <= wr_ptr + PTR_W'(sext_delay(32'(delay), DELAY_WIDTH)) + PTR_W'(1);
        dly_reg <= delay;
      end else begin
        wr_addr <= wr_addr + PTR_W'(1);
      end
    end
  end
`else
  logic unused_delay;
  assign unused_delay = ^delay;
  assign wr_addr      = wr_ptr;
`endif

  // NOTE: the storage array has no reset; reset only rewinds the pointers around it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
  end

  assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];

  axi_fifo_dly_ostage #(
    .WIDTH (WORD_W)
  ) u_ostage (
    .clk        (clk),
    .sync_reset (sync_reset),
    .src_valid  (!empty),
    .src_data   (rd_word),
    .src_pop    (rd_en),
    .dst_valid  (m_axis.tvalid),
    .dst_data   (out_word),
    .dst_ready  (m_axis.tready)
  );

  assign m_axis.tdata = out_word[DATA_WIDTH-1:0];
  assign m_axis.tlast = out_word[DATA_WIDTH];

endmodule
